// File: rtl/button_event_pkg.sv
// Shared constants and types for the two-channel button event capture block.
package button_event_pkg;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned CH_IRQ  = 0;
  localparam int unsigned CH_HOUR = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } ch_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_capture_channel.sv
// One button channel: 2-flop synchronizer, debounce filter and press/hold/repeat FSM.
module button_channel
  import button_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic evt
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [1:0]        sync;
  logic [DB_W-1:0]   db_cnt;
  logic              mismatch, db_hit, rise, fall;
  ch_state_t         state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [REP_W-1:0]  rep_cnt, rep_next;

  // Reset loads the released (high) level so a held key still debounces in full.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  assign mismatch = (~sync[1]) != pressed;
  assign db_hit   = mismatch && (db_cnt == DB_LAST);
  assign rise     = db_hit && !pressed;
  assign fall     = db_hit && pressed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (!mismatch) begin
      db_cnt  <= '0;
    end else if (db_hit) begin
      db_cnt  <= '0;
      pressed <= ~pressed;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      rep_cnt  <= rep_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    rep_next   = rep_cnt;
    evt        = 1'b0;
    if (fall) begin
      state_next = ST_IDLE;
      hold_next  = '0;
      rep_next   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            evt        = 1'b1;
            state_next = ST_HOLD;
            hold_next  = '0;
          end
        end
        ST_HOLD: begin
          // Without repeat the hold counter parks at its last value.
          if (hold_cnt == HOLD_LAST) begin
            if (REPEAT_EN) begin
              evt        = 1'b1;
              state_next = ST_REPEAT;
              rep_next   = '0;
            end
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rep_cnt == REP_LAST) begin
            evt      = 1'b1;
            rep_next = '0;
          end else begin
            rep_next = rep_cnt + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_event_capture.sv
// Two debounced button channels with sticky pending/overrun flags and a masked interrupt.
module button_event_capture
  import button_event_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter int unsigned       HOLD_CYCLES     = 25000000,
  parameter int unsigned       REPEAT_CYCLES   = 5000000,
  parameter logic [NUM_CH-1:0] REPEAT_EN       = 2'b10
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_CH-1:0] key_n,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] pressed_export,
  output logic [NUM_CH-1:0] pending_export,
  output logic [NUM_CH-1:0] overrun_export,
  output logic              irq
);

  logic [NUM_CH-1:0] evt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_channel (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .key_n  (key_n[i]),
      .pressed(pressed_export[i]),
      .evt    (evt[i])
    );
  end

  // An event wins over a coincident clear for pending; the clear wins for overrun.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pending_export <= '0;
      overrun_export <= '0;
      irq            <= 1'b0;
    end else begin
      pending_export <= (pending_export & ~clear) | evt;
      overrun_export <= (overrun_export & ~clear) | (evt & pending_export & ~clear);
      irq            <= |(pending_export & irq_mask);
    end
  end

endmodule

// File: tb/tb_button_event_capture.sv
// Directed and randomized bench for button_event_capture against a behavioural model.
module tb_button_event_capture;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  localparam logic [1:0] REN = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [1:0] irq_mask = 2'b11;
  logic [1:0] clear = 2'b00;
  logic [1:0] pressed, pending, overrun;
  logic       irq;

  int tests = 0;
  int failed = 0;

  button_event_capture #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .REPEAT_EN      (REN)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .key_n         (key_n),
    .irq_mask      (irq_mask),
    .clear         (clear),
    .pressed_export(pressed),
    .pending_export(pending),
    .overrun_export(overrun),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw level seen two edges late, run-length debounce,
  // events derived from the age of the current press.
  logic [1:0] hist[$] = '{2'b11, 2'b11, 2'b11};
  bit         m_pressed[2];
  int         mism[2];
  int         age[2];
  logic [1:0] m_pend = 2'b00;
  logic [1:0] m_ov = 2'b00;
  logic       m_irq = 1'b0;

  always @(posedge clk) begin
    logic [1:0] ev;
    logic [1:0] raw;
    logic       irq_new;
    bit         level;
    hist.push_front(rst_n ? key_n : 2'b11);
    void'(hist.pop_back());
    raw = hist[2];
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_pressed[c] = 1'b0;
        mism[c]      = 0;
        age[c]       = -1;
      end
      m_pend = 2'b00;
      m_ov   = 2'b00;
      m_irq  = 1'b0;
    end else begin
      irq_new = |(m_pend & irq_mask);
      ev = 2'b00;
      for (int c = 0; c < 2; c++) begin
        level = ~raw[c];
        mism[c] = (level != m_pressed[c]) ? mism[c] + 1 : 0;
        if (mism[c] == D) begin
          m_pressed[c] = level;
          mism[c]      = 0;
          age[c]       = level ? 0 : -1;
          ev[c]        = level;
        end else if (m_pressed[c]) begin
          age[c]++;
          if (REN[c] && age[c] >= H && (age[c] - H) % R == 0) ev[c] = 1'b1;
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (ev[c] && clear[c]) begin
          m_pend[c] = 1'b1;
          m_ov[c]   = 1'b0;
        end else if (ev[c]) begin
          m_ov[c]   = m_ov[c] | m_pend[c];
          m_pend[c] = 1'b1;
        end else if (clear[c]) begin
          m_pend[c] = 1'b0;
          m_ov[c]   = 1'b0;
        end
      end
      m_irq = irq_new;
    end
    #1;
    check("model_pressed", 32'(pressed), 32'({m_pressed[1], m_pressed[0]}));
    check("model_pending", 32'(pending), 32'(m_pend));
    check("model_overrun", 32'(overrun), 32'(m_ov));
    check("model_irq",     32'(irq),     32'(m_irq));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ev_cyc[$];
  int remain[2];

  initial begin
    tick(3);
    check("reset_state", 32'({pressed, pending, overrun, irq}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single press on channel 0: exact debounce latency, then irq one edge later.
    key_n[0] = 1'b0;
    tick(5);
    check("press_lat_before", 32'(pressed[0]), 32'd0);
    tick(1);
    check("press_lat_pressed", 32'(pressed[0]), 32'd1);
    check("press_lat_pending", 32'(pending[0]), 32'd1);
    check("press_irq_not_yet", 32'(irq), 32'd0);
    tick(1);
    check("press_irq", 32'(irq), 32'd1);
    tick(40);
    check("no_repeat_ch0", 32'(overrun[0]), 32'd0);
    key_n[0] = 1'b1;
    tick(10);
    clear = 2'b01;
    tick(1);
    clear = 2'b00;
    tick(2);
    check("cleared_ch0", 32'({pending[0], irq}), 32'd0);

    // Short glitches never reach the debounce threshold.
    for (int g = 0; g < 4; g++) begin
      key_n[0] = 1'b0;
      tick(3);
      key_n[0] = 1'b1;
      tick(5);
    end
    check("glitch_pressed", 32'(pressed[0]), 32'd0);
    check("glitch_pending", 32'(pending[0]), 32'd0);
    check("glitch_irq", 32'(irq), 32'd0);

    // Held hour key: press, first repeat after H, then every R; cleared each time.
    key_n[1] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (pending[1]) begin
        ev_cyc.push_back(c);
        clear = 2'b10;
      end else begin
        clear = 2'b00;
      end
    end
    clear = 2'b00;
    key_n[1] = 1'b1;
    check("repeat_count", 32'(ev_cyc.size()), 32'd6);
    if (ev_cyc.size() == 6) begin
      check("repeat_first", 32'(ev_cyc[0]), 32'd6);
      check("repeat_hold_gap", 32'(ev_cyc[1] - ev_cyc[0]), 32'd20);
      check("repeat_period", 32'(ev_cyc[2] - ev_cyc[1]), 32'd8);
      check("repeat_period_last", 32'(ev_cyc[5] - ev_cyc[4]), 32'd8);
    end
    check("repeat_no_overrun", 32'(overrun[1]), 32'd0);
    tick(12);
    clear = 2'b10;
    tick(1);
    clear = 2'b00;

    // Second press without clear overruns; clear coincident with the third event.
    for (int p = 0; p < 2; p++) begin
      key_n[0] = 1'b0;
      tick(12);
      key_n[0] = 1'b1;
      tick(12);
    end
    check("overrun_set", 32'(overrun[0]), 32'd1);
    key_n[0] = 1'b0;
    tick(5);
    clear = 2'b01;
    tick(1);
    clear = 2'b00;
    check("clear_vs_event_pending", 32'(pending[0]), 32'd1);
    check("clear_vs_event_overrun", 32'(overrun[0]), 32'd0);
    key_n[0] = 1'b1;
    tick(10);
    clear = 2'b01;
    tick(1);
    clear = 2'b00;

    // Reset while auto-repeating with the key still held.
    key_n[1] = 1'b0;
    tick(34);
    rst_n = 1'b0;
    tick(2);
    check("reset_mid_repeat", 32'({pressed, pending, overrun, irq}), 32'd0);
    rst_n = 1'b1;
    tick(5);
    check("rst_release_before", 32'({pressed[1], pending[1]}), 32'd0);
    tick(1);
    check("rst_release_press", 32'({pressed[1], pending[1]}), 32'b11);
    tick(12);
    check("rst_release_single", 32'(overrun[1]), 32'd0);
    key_n[1] = 1'b1;
    tick(10);

    // Randomized keys, clears, masks and occasional resets.
    remain[0] = 0;
    remain[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (remain[c] == 0) begin
          key_n[c]  = 1'($urandom_range(0, 1));
          remain[c] = ($urandom % 4 == 0) ? $urandom_range(1, 5) : $urandom_range(6, 50);
        end
        remain[c]--;
      end
      clear = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
      if ($urandom % 50 == 0) irq_mask = 2'($urandom);
      rst_n = ($urandom % 400 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    clear = 2'b00;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/button_event_capture.md
BUTTON_EVENT_CAPTURE -- requirements
Module: button_event_capture

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: the number of consecutive stable synchronized samples needed to accept a level change (minimum 2).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 25000000: the number of cycles a press must be held before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 5000000: the auto-repeat period.
REQ-004 The block SHALL have parameter REPEAT_EN, default 2'b10: the per-channel auto-repeat enable (bit1 = hour changer).
REQ-005 The block SHALL have port clk_clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port reset_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port key_n, input, 2 bits: raw asynchronous active-low buttons (bit0 = interrupt button, bit1 = hour changer).
REQ-008 The block SHALL have port irq_mask, input, 2 bits: per-channel interrupt enable.
REQ-009 The block SHALL have port clear, input, 2 bits: write-one-to-clear pulse for pending and overrun.
REQ-010 The block SHALL have port pressed_export, output, 2 bits: debounced level (1 = pressed).
REQ-011 The block SHALL have port pending_export, output, 2 bits: sticky event flags.
REQ-012 The block SHALL have port overrun_export, output, 2 bits: sticky flags set when an event occurs while pending is already set.
REQ-013 The block SHALL have port irq, output, 1 bit: the interrupt request.

Function
REQ-014 Each key_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: on each edge where the synchronized sample differs from pressed, a counter SHALL increment; on the edge of the DEBOUNCE_CYCLES-th consecutive mismatch, pressed SHALL update and the counter SHALL clear.
REQ-016 Any matching sample SHALL clear the debounce counter; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no change.
REQ-017 Latency from the first edge sampling a new stable raw level to the pressed update SHALL be exactly DEBOUNCE_CYCLES+2 edges.
REQ-018 Each channel SHALL run an FSM with states IDLE, HOLD and REPEAT.
REQ-019 In IDLE, a pressed 0->1 transition SHALL generate a press event and move the FSM to HOLD with the hold counter at 0.
REQ-020 In HOLD with REPEAT_EN set, reaching HOLD_CYCLES-1 SHALL generate a repeat event and move the FSM to REPEAT; with REPEAT_EN clear, the FSM SHALL stay in HOLD.
REQ-021 In REPEAT, the FSM SHALL generate a repeat event every REPEAT_CYCLES cycles.
REQ-022 A pressed 1->0 transition SHALL return the FSM to IDLE from any state; release SHALL generate no event.
REQ-023 Events SHALL set pending on the same edge as the event.
REQ-024 If an event occurs while pending is already 1, overrun SHALL be set.
REQ-025 A clear bit SHALL zero the matching pending and overrun bits on the next edge.
REQ-026 On a simultaneous event and clear, pending SHALL end at 1 and overrun SHALL end at 0.
REQ-027 irq SHALL be registered and equal to OR(pending & irq_mask), one edge after the inputs change.
REQ-028 The two channels SHALL be fully independent; simultaneous events on both channels SHALL both be captured.
REQ-029 All counters SHALL saturate or reload; none SHALL wrap to generate a spurious event.

Reset
REQ-030 While reset_reset_n is 0 at an edge: synchronizers SHALL load the released level (1), pressed/pending/overrun/irq SHALL be 0, counters SHALL be 0, and the FSMs SHALL be IDLE.
REQ-031 A button held across reset release SHALL register as one press exactly DEBOUNCE_CYCLES+2 edges after release.
REQ-032 Reset mid-debounce or mid-repeat SHALL discard all partial counts.

Structure
REQ-033 Package button_event_pkg SHALL hold the channel count (2), the channel index constants and the FSM state enum.
REQ-034 Sub-module button_channel (synchronizer, debounce, FSM; outputs pressed and event pulse) SHALL be instantiated twice; the top SHALL hold pending, overrun and irq.
REQ-035 Counter widths SHALL be derived with $clog2 of the parameters.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, irq_mask=2'b11)
REQ-036 Drive key_n[0]=0 held -> pressed[0]=1 and pending[0]=1 exactly 6 edges later, irq=1 one edge after that, and no further events.
REQ-037 Drive 3-cycle low glitches on key_n[0] -> pressed, pending and irq stay 0.
REQ-038 Hold key_n[1]=0 for 60 cycles -> press event, repeat at +20 cycles, then every 8 cycles; clear after each event keeps overrun=0.
REQ-039 Send a second press without clear -> overrun[0]=1; then clear=2'b01 coincident with a third event -> pending[0]=1 and overrun[0]=0.
REQ-040 Assert reset during REPEAT -> all outputs 0; with the key still held, one press event 6 edges after reset release.
